// File: rtl/go_pkg.sv
// Shared types and defaults for the Go board controller.
package go_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } stone_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT,
    OVER
  } ctrl_state_t;

  localparam int unsigned BOARD_N_DEFAULT    = 9;
  localparam int unsigned PASS_LIMIT_DEFAULT = 2;
  localparam logic [3:0]  CURSOR_HOME        = 4'd4;

  function automatic stone_t other_stone(stone_t s);
    return (s == BLACK) ? WHITE : BLACK;
  endfunction

  // One saturating step on a cursor axis; opposing requests cancel.
  function automatic logic [3:0] sat_step(logic [3:0] pos, logic dec, logic inc,
                                          logic [3:0] max_idx);
    logic [3:0] res;
    res = pos;
    if (inc && !dec && pos != max_idx) res = pos + 4'd1;
    else if (dec && !inc && pos != 4'd0) res = pos - 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/go_cursor.sv
// Board cursor: two saturating counters driven by the direction buttons.
module go_cursor
  import go_pkg::*;
#(
  parameter int unsigned BOARD_N = BOARD_N_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] row,
  output logic [3:0] col
);

  localparam logic [3:0] MaxIdx = 4'(BOARD_N - 1);

  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;

  always_comb begin
    row_d = sat_step(row_q, btn_up, btn_down, MaxIdx);
    col_d = sat_step(col_q, btn_left, btn_right, MaxIdx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= CURSOR_HOME;
      col_q <= CURSOR_HOME;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/go_board_ctrl.sv
// Go board-state owner: accepts button or external moves, checks occupancy,
// writes stones, alternates turns and ends the game on consecutive passes.
module go_board_ctrl
  import go_pkg::*;
#(
  parameter int unsigned BOARD_N    = BOARD_N_DEFAULT,
  parameter int unsigned PASS_LIMIT = PASS_LIMIT_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 new_game,
  input  logic                                 btn_up,
  input  logic                                 btn_down,
  input  logic                                 btn_left,
  input  logic                                 btn_right,
  input  logic                                 btn_place,
  input  logic                                 btn_pass,
  input  logic                                 mv_valid,
  input  logic                                 mv_pass,
  input  logic [3:0]                           mv_row,
  input  logic [3:0]                           mv_col,
  output logic                                 mv_ready,
  output logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board,
  output logic [3:0]                           cursor_row,
  output logic [3:0]                           cursor_col,
  output logic [1:0]                           turn,
  output logic                                 move_done,
  output logic                                 move_illegal,
  output logic                                 game_over,
  output logic [6:0]                           move_count
);

  localparam int unsigned PassW  = $clog2(PASS_LIMIT + 1);
  localparam logic [3:0]  MaxIdx = 4'(BOARD_N - 1);

  ctrl_state_t                          state_q, state_d;
  stone_t                               turn_q, turn_d;
  logic [PassW-1:0]                     pass_q, pass_d;
  logic [6:0]                           count_q, count_d;
  logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_q, board_d;
  logic [3:0]                           tgt_row_q, tgt_row_d;
  logic [3:0]                           tgt_col_q, tgt_col_d;
  logic                                 done_q, done_d;
  logic                                 illegal_q, illegal_d;
  logic                                 over_q, over_d;
  logic                                 tgt_in_range;
  logic                                 tgt_occupied;
  logic                                 do_pass;

  go_cursor #(
    .BOARD_N (BOARD_N)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .row       (cursor_row),
    .col       (cursor_col)
  );

  assign mv_ready     = (state_q == IDLE) & ~btn_place & ~btn_pass;
  assign tgt_in_range = (tgt_row_q <= MaxIdx) && (tgt_col_q <= MaxIdx);
  assign tgt_occupied = tgt_in_range && (board_q[tgt_row_q][tgt_col_q] != 2'(EMPTY));

  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    pass_d    = pass_q;
    count_d   = count_q;
    board_d   = board_q;
    tgt_row_d = tgt_row_q;
    tgt_col_d = tgt_col_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    over_d    = over_q;
    do_pass   = 1'b0;

    if (new_game) begin
      // Also aborts any in-flight CHECK/COMMIT before it writes.
      board_d = '0;
      turn_d  = BLACK;
      pass_d  = '0;
      count_d = '0;
      over_d  = 1'b0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_place) begin
            tgt_row_d = cursor_row;
            tgt_col_d = cursor_col;
            state_d   = CHECK;
          end else if (btn_pass || (mv_valid && mv_ready && mv_pass)) begin
            do_pass = 1'b1;
          end else if (mv_valid && mv_ready) begin
            tgt_row_d = mv_row;
            tgt_col_d = mv_col;
            state_d   = CHECK;
          end
          if (do_pass) begin
            turn_d = other_stone(turn_q);
            pass_d = pass_q + PassW'(1);
            if (pass_d == PassW'(PASS_LIMIT)) begin
              state_d = OVER;
              over_d  = 1'b1;
            end
          end
        end
        CHECK: begin
          if (!tgt_in_range || tgt_occupied) begin
            illegal_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = COMMIT;
          end
        end
        COMMIT: begin
          board_d[tgt_row_q][tgt_col_q] = turn_q;
          turn_d  = other_stone(turn_q);
          pass_d  = '0;
          count_d = count_q + 7'd1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      turn_q    <= BLACK;
      pass_q    <= '0;
      count_q   <= '0;
      board_q   <= '0;
      tgt_row_q <= '0;
      tgt_col_q <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      pass_q    <= pass_d;
      count_q   <= count_d;
      board_q   <= board_d;
      tgt_row_q <= tgt_row_d;
      tgt_col_q <= tgt_col_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      over_q    <= over_d;
    end
  end

  assign board        = board_q;
  assign turn         = turn_q;
  assign move_done    = done_q;
  assign move_illegal = illegal_q;
  assign game_over    = over_q;
  assign move_count   = count_q;

endmodule
